// File: rtl/hl_stream_stage_if.sv
// Token stream bundle for hl_stream_stage: In1 producer side and Out1 consumer side.
// The slave modport is the stage's view; master is the environment that drives it.
interface hl_stream_stage_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] In1_DATA;
  logic              In1_SEND;
  logic [15:0]       In1_COUNT;
  logic              In1_ACK;
  logic [DATA_W-1:0] Out1_DATA;
  logic              Out1_SEND;
  logic [15:0]       Out1_COUNT;
  logic              Out1_RDY;
  logic              Out1_ACK;

  modport slave (
    input  In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
    output In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT
  );

  modport master (
    output In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
    input  In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT
  );
endinterface

// File: rtl/hl_stream_stage.sv
// Decimating FIFO stream stage: keeps every DECIM-th accepted token and buffers it.
// Define HL_STREAM_STAGE_STATS_EN to add the saturating TOKENS_OUT transfer counter.
module hl_stream_stage #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int DECIM  = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  hl_stream_stage_if.slave         bus,
  output logic [$clog2(DEPTH):0]   LEVEL
`ifdef HL_STREAM_STAGE_STATS_EN
  ,
  output logic [31:0]              TOKENS_OUT
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);
  localparam logic [7:0]     PHASE_LAST = 8'(DECIM - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W:0]    r_level;
  logic [7:0]        r_phase;

  logic w_full;
  logic w_empty;
  logic w_ack;
  logic w_push;
  logic w_pop;
  logic w_unused;

  // Full comes from the registered level only, so a same-cycle pop never frees a slot early.
  assign w_full   = (r_level == FULL_LEVEL);
  assign w_empty  = (r_level == '0);
  assign w_ack    = bus.In1_SEND & ~w_full & ~RESET;
  assign w_push   = w_ack & (r_phase == 8'd0);
  assign w_pop    = bus.Out1_SEND;
  assign w_unused = ^{bus.In1_COUNT, bus.Out1_ACK};

  assign bus.In1_ACK    = w_ack;
  assign bus.Out1_SEND  = ~w_empty & bus.Out1_RDY & ~RESET;
  assign bus.Out1_DATA  = w_empty ? '0 : r_mem[r_rdPtr];
  assign bus.Out1_COUNT = 16'h0001;
  assign LEVEL          = r_level;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= bus.In1_DATA;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_phase <= 8'd0;
    end else if (w_ack) begin
      r_phase <= (r_phase == PHASE_LAST) ? 8'd0 : r_phase + 8'd1;
    end
  end

`ifdef HL_STREAM_STAGE_STATS_EN
  logic [31:0] r_tokensOut;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tokensOut <= 32'd0;
    end else if (w_pop && (r_tokensOut != 32'hFFFF_FFFF)) begin
      r_tokensOut <= r_tokensOut + 32'd1;
    end
  end

  assign TOKENS_OUT = r_tokensOut;
`endif

endmodule

// File: tb/tb_hl_stream_stage.sv
// Scoreboard bench for hl_stream_stage: two instances (DECIM=1 and DECIM=3) share one
// randomized stimulus stream and are checked every cycle against queue-based models.
module tb_hl_stream_stage;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 4;
  localparam int DECIM_A = 1;
  localparam int DECIM_B = 3;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        tbSend = 1'b0;
  logic [15:0] tbData = 16'h0;
  logic        tbRdy = 1'b0;

  int errors = 0;
  int checks = 0;

  hl_stream_stage_if #(.DATA_W(DATA_W)) busA ();
  hl_stream_stage_if #(.DATA_W(DATA_W)) busB ();

  logic [2:0]  levelA;
  logic [2:0]  levelB;
  logic [31:0] tokOutA;
  logic [31:0] tokOutB;

  assign busA.In1_DATA  = tbData;
  assign busA.In1_SEND  = tbSend;
  assign busA.In1_COUNT = 16'h0001;
  assign busA.Out1_RDY  = tbRdy;
  assign busA.Out1_ACK  = busA.Out1_SEND;
  assign busB.In1_DATA  = tbData;
  assign busB.In1_SEND  = tbSend;
  assign busB.In1_COUNT = 16'h0001;
  assign busB.Out1_RDY  = tbRdy;
  assign busB.Out1_ACK  = busB.Out1_SEND;

  hl_stream_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DECIM(DECIM_A)) dutA (
    .CLK        (CLK),
    .RESET      (RESET),
    .bus        (busA.slave),
    .LEVEL      (levelA)
`ifdef HL_STREAM_STAGE_STATS_EN
    ,
    .TOKENS_OUT (tokOutA)
`endif
  );

  hl_stream_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DECIM(DECIM_B)) dutB (
    .CLK        (CLK),
    .RESET      (RESET),
    .bus        (busB.slave),
    .LEVEL      (levelB)
`ifdef HL_STREAM_STAGE_STATS_EN
    ,
    .TOKENS_OUT (tokOutB)
`endif
  );

`ifndef HL_STREAM_STAGE_STATS_EN
  assign tokOutA = 32'h0;
  assign tokOutB = 32'h0;
`endif

  always #5 CLK = ~CLK;

  // Reference model: expected FIFO contents per instance, count of accepted tokens
  // since reset (a token is kept when that count is a multiple of DECIM), transfer totals.
  logic [15:0] qA [$];
  logic [15:0] qB [$];
  int unsigned accA = 0;
  int unsigned accB = 0;
  logic [31:0] tokA = 32'h0;
  logic [31:0] tokB = 32'h0;

  task automatic checkOutput(input string name, input int id, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0h expected %0h", name, id, $time, actual, expected);
    end
  endtask

  task automatic checkDut(input int id, input logic ack, input logic send, input logic [15:0] data,
                          input logic [2:0] level, input logic [15:0] cnt, input logic [31:0] tok);
    int          sz;
    logic [15:0] head;
    logic        expAck;
    logic        expSend;
    int          decim;
    int unsigned acc;
    sz    = (id == 0) ? qA.size() : qB.size();
    head  = (sz == 0) ? 16'h0 : ((id == 0) ? qA[0] : qB[0]);
    decim = (id == 0) ? DECIM_A : DECIM_B;
    acc   = (id == 0) ? accA : accB;
    expAck  = !RESET && tbSend && (sz < DEPTH);
    expSend = !RESET && (sz != 0) && tbRdy;
    checkOutput("in_ack", id, 32'(ack), 32'(expAck));
    checkOutput("out_send", id, 32'(send), 32'(expSend));
    checkOutput("out_data", id, 32'(data), 32'(head));
    checkOutput("level", id, 32'(level), 32'(sz));
    checkOutput("out_count", id, 32'(cnt), 32'h1);
`ifdef HL_STREAM_STAGE_STATS_EN
    checkOutput("tokens_out", id, tok, (id == 0) ? tokA : tokB);
`else
    if (tok != 32'h0) begin
      checkOutput("tokens_tie", id, tok, 32'h0);
    end
`endif
    if (!RESET) begin
      if (expSend) begin
        if (id == 0) begin
          void'(qA.pop_front());
          if (tokA != 32'hFFFF_FFFF) tokA++;
        end else begin
          void'(qB.pop_front());
          if (tokB != 32'hFFFF_FFFF) tokB++;
        end
      end
      if (expAck) begin
        if ((acc % decim) == 0) begin
          if (id == 0) qA.push_back(tbData);
          else qB.push_back(tbData);
        end
        if (id == 0) accA++;
        else accB++;
      end
    end
  endtask

  always @(negedge CLK) begin
    checkDut(0, busA.In1_ACK, busA.Out1_SEND, busA.Out1_DATA, levelA, busA.Out1_COUNT, tokOutA);
    checkDut(1, busB.In1_ACK, busB.Out1_SEND, busB.Out1_DATA, levelB, busB.Out1_COUNT, tokOutB);
  end

  task automatic applyStimulus(input logic send, input logic [15:0] data, input logic rdy);
    tbSend = send;
    tbData = data;
    tbRdy  = rdy;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    repeat (8) applyStimulus(1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;

    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(i), 1'b1);
    drain();

    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 16'(16'h10 + i), 1'b1);
    drain();

    // Stall the sink so instance A fills; two extra offers must be refused.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'(16'h20 + i), 1'b0);
    checkOutput("full_level", 0, 32'(levelA), 32'd4);
    checkOutput("full_ack", 0, 32'(busA.In1_ACK), 32'd0);
    drain();

    applyStimulus(1'b1, 16'h30, 1'b0);
    applyStimulus(1'b1, 16'h31, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'(16'h40 + i), 1'b1);
    checkOutput("pushpop_level", 0, 32'(levelA), 32'd2);
    drain();

    repeat (300) applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) != 0));
    drain();

    // Asynchronous reset between edges with three tokens buffered in instance A.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(16'h50 + i), 1'b0);
    tbSend = 1'b1;
    tbRdy  = 1'b1;
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("rst_level", 0, 32'(levelA), 32'd0);
    checkOutput("rst_send", 0, 32'(busA.Out1_SEND), 32'd0);
    checkOutput("rst_ack", 0, 32'(busA.In1_ACK), 32'd0);
    checkOutput("rst_level", 1, 32'(levelB), 32'd0);
    qA.delete();
    qB.delete();
    accA = 0;
    accB = 0;
    tokA = 32'h0;
    tokB = 32'h0;
    tbSend = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    applyStimulus(1'b1, 16'h60, 1'b1);
    applyStimulus(1'b1, 16'h61, 1'b1);
    drain();

    repeat (200) applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 1) != 0));
    drain();

`ifdef HL_STREAM_STAGE_STATS_EN
    force dutA.r_tokensOut = 32'hFFFF_FFFF;
    #1;
    release dutA.r_tokensOut;
    tokA = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 16'h70, 1'b1);
    drain();
    checkOutput("tokens_sat", 0, tokOutA, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
